cpu_mc_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences one shared datapath through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/cpu_mc_sequencer_pkg.sv | 38 +++
 rtl/cpu_mc_sequencer_if.sv | 20 ++
 rtl/cpu_mc_sequencer_mem_wait_timer.sv | 31 +++
 rtl/cpu_mc_sequencer.sv | 144 ++++++++++++++
 tb/tb_cpu_mc_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mc_sequencer_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer: FSM states,
// trap causes and the decoder control word the sequencer qualifies.
package cpu_mc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } t_mc_state;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_ILLEGAL = 2'd1,
    TRAP_IMEM_TO = 2'd2,
    TRAP_DMEM_TO = 2'd3
  } t_trap_cause;

  // Subset of the decoder control word that the sequencer looks at.
  typedef struct packed {
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic       sel_dmem_wb;
    logic [3:0] mem_byt_en;
  } t_ctrl;

  function automatic logic is_load(t_ctrl c);
    return c.sel_dmem_wb;
  endfunction

  function automatic logic is_mem_op(t_ctrl c);
    return c.sel_dmem_wb | c.mem_wr_en;
  endfunction

endpackage

// File: rtl/cpu_mc_sequencer_if.sv
// Instruction/data memory request-acknowledge bundle between the sequencer
// (master) and the memory side (slave).
interface cpu_mc_sequencer_if;
  logic       imem_req;
  logic       imem_ack;
  logic       dmem_req;
  logic       dmem_ack;
  logic       dmem_we;
  logic [3:0] dmem_be;

  modport master (
    output imem_req, dmem_req, dmem_we, dmem_be,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, dmem_be,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/cpu_mc_sequencer_mem_wait_timer.sv
// Wait-state watchdog shared by the FETCH and MEM waits. expired is high on
// the last permitted wait cycle; TIMEOUT_CYC = 0 disables it.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && (count == LAST);

endmodule

// File: rtl/cpu_mc_sequencer.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the RV32I core.
// Optional performance counters are built when CPU_MC_PERF_EN is defined.
module cpu_mc_sequencer
  import cpu_mc_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  t_ctrl                ctrl,
  input  logic                 illegal,
  input  logic                 halt,
  cpu_mc_sequencer_if.master   mem,
  output logic                 ir_ld_en,
  output logic                 mdr_ld_en,
  output logic                 reg_wr_en,
  output logic                 pc_wr_en,
  output logic                 instr_done,
  output logic                 trap,
  output t_trap_cause          trap_cause,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
);

  t_mc_state   state, state_nx;
  t_trap_cause cause_nx;
  logic        waiting, cur_ack, tmr_expired;

  // The timer only runs while parked in a wait state; any other state clears
  // it, so it always starts from zero on entry to FETCH or MEM.
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign cur_ack = (state == S_FETCH) ? mem.imem_ack : mem.dmem_ack;

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .inc     (waiting && !cur_ack),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      trap_cause <= TRAP_NONE;
    end else begin
      state      <= state_nx;
      trap_cause <= cause_nx;
    end
  end

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    cause_nx = trap_cause;
    unique case (state)
      S_IDLE:   if (!halt) state_nx = S_FETCH;
      S_FETCH: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (mem.imem_ack) begin
          state_nx = S_DECODE;
        end else if (tmr_expired) begin
          state_nx = S_TRAP;
          cause_nx = TRAP_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_nx = S_TRAP;
          cause_nx = TRAP_ILLEGAL;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC:   state_nx = is_mem_op(ctrl) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem.dmem_ack) begin
          state_nx = S_WB;
        end else if (tmr_expired) begin
          state_nx = S_TRAP;
          cause_nx = TRAP_DMEM_TO;
        end
      end
      S_WB:     state_nx = halt ? S_IDLE : S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Moore outputs; only the register loads look at the ack of the cycle.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    mem.dmem_be  = 4'b0000;
    ir_ld_en     = 1'b0;
    mdr_ld_en    = 1'b0;
    reg_wr_en    = 1'b0;
    pc_wr_en     = 1'b0;
    instr_done   = 1'b0;
    trap         = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_ld_en     = mem.imem_ack;
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = ctrl.mem_wr_en;
        mem.dmem_be  = ctrl.mem_byt_en;
        mdr_ld_en    = mem.dmem_ack && is_load(ctrl);
      end
      S_WB: begin
        reg_wr_en  = ctrl.reg_wr_en;
        pc_wr_en   = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

`ifdef CPU_MC_PERF_EN
  logic active;
  assign active = (state != S_IDLE) && (state != S_TRAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (active)     cycle_cnt   <= cycle_cnt + 1'b1;
      if (instr_done) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_mc_sequencer.sv
// Scoreboard bench for cpu_mc_sequencer: stimulus queues expected output
// snapshots, a negedge monitor pops and compares them on every DUT event.
module tb_cpu_mc_sequencer;
  import cpu_mc_sequencer_pkg::*;

  localparam int unsigned TMO = 8;

  typedef struct packed {
    logic       imem_req;
    logic       ir_ld;
    logic       dmem_req;
    logic       dmem_we;
    logic [3:0] be;
    logic       mdr_ld;
    logic       reg_wr;
    logic       pc_wr;
    logic       done;
    logic       trap;
    logic [1:0] cause;
  } snap_t;

  typedef struct {
    string name;
    snap_t s;
    int    c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  t_ctrl       ctrl = '0;
  logic        illegal = 1'b0;
  logic        halt = 1'b0;
  logic        ir_ld_en, mdr_ld_en, reg_wr_en, pc_wr_en, instr_done, trap;
  t_trap_cause trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;

  cpu_mc_sequencer_if bus ();

  cpu_mc_sequencer #(
    .TIMEOUT_CYC (TMO),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl        (ctrl),
    .illegal     (illegal),
    .halt        (halt),
    .mem         (bus),
    .ir_ld_en    (ir_ld_en),
    .mdr_ld_en   (mdr_ld_en),
    .reg_wr_en   (reg_wr_en),
    .pc_wr_en    (pc_wr_en),
    .instr_done  (instr_done),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   dreq_cyc = 0;
  int   strobe_cyc = 0;

  localparam t_ctrl C_ADD = '{reg_wr_en: 1'b1, mem_wr_en: 1'b0, sel_dmem_wb: 1'b0, mem_byt_en: 4'b0000};
  localparam t_ctrl C_LW  = '{reg_wr_en: 1'b1, mem_wr_en: 1'b0, sel_dmem_wb: 1'b1, mem_byt_en: 4'b1111};
  localparam t_ctrl C_SH  = '{reg_wr_en: 1'b0, mem_wr_en: 1'b1, sel_dmem_wb: 1'b0, mem_byt_en: 4'b0011};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic snap_t mk(logic ir, logic ild, logic dr, logic we, logic [3:0] be,
                               logic mdr, logic rw, logic pw, logic dn, logic tr, logic [1:0] cs);
    return {ir, ild, dr, we, be, mdr, rw, pw, dn, tr, cs};
  endfunction

  function automatic snap_t cur_snap();
    return mk(bus.imem_req, ir_ld_en, bus.dmem_req, bus.dmem_we, bus.dmem_be,
              mdr_ld_en, reg_wr_en, pc_wr_en, instr_done, trap, trap_cause);
  endfunction

  task automatic push(input string name, input snap_t s, input int c);
    exp_t e;
    e.name = name;
    e.s    = s;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  task automatic push_ir(input int c);
    push("ir_load", mk(1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0), c);
  endtask

  task automatic push_mem(input logic we, input logic [3:0] be, input logic mdr, input int c);
    push("mem_ack", mk(0, 0, 1, we, be, mdr, 0, 0, 0, 0, 2'd0), c);
  endtask

  task automatic push_done(input logic rw, input int c);
    push("writeback", mk(0, 0, 0, 0, 4'h0, 0, rw, 1, 1, 0, 2'd0), c);
  endtask

  task automatic push_trap(input logic [1:0] cs, input int c);
    push("trap", mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, cs), c);
  endtask

  // Monitor: fcyc counts cycles since FETCH entry (1 = first FETCH cycle).
  initial begin : monitor
    int   fcyc;
    logic req_q, trap_q, ev;
    exp_t e;
    fcyc = 0;
    req_q = 1'b0;
    trap_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fcyc = 0;
        req_q = 1'b0;
        trap_q = 1'b0;
      end else begin
        if (bus.imem_req && !req_q) fcyc = 1;
        else                        fcyc++;
        req_q = bus.imem_req;
        if (bus.dmem_req) dreq_cyc++;
        if (bus.dmem_req || reg_wr_en || pc_wr_en) strobe_cyc++;
        ev = ir_ld_en | (bus.dmem_req & bus.dmem_ack) | instr_done | (trap & !trap_q);
        if (ev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", cur_snap(), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_outputs"}, cur_snap(), e.s);
            check({e.name, "_cycle"}, fcyc, e.c);
          end
        end
        trap_q = trap;
      end
    end
  end

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ctrl = '0;
    illegal = 1'b0;
    halt = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Instruction memory: wait for req, add n wait cycles, then ack with the decoded ctrl.
  task automatic fetch(input int n, input t_ctrl c, input logic ill);
    int k;
    k = 0;
    while (!bus.imem_req && k < 40) begin
      step();
      k++;
    end
    if (!bus.imem_req) begin
      check("imem_req_wait_expired", 32'd0, 32'd1);
      return;
    end
    repeat (n) step();
    bus.imem_ack = 1'b1;
    ctrl = c;
    illegal = ill;
    step();
    bus.imem_ack = 1'b0;
  endtask

  task automatic wait_dreq();
    int k;
    k = 0;
    while (!bus.dmem_req && k < 40) begin
      step();
      k++;
    end
    if (!bus.dmem_req) check("dmem_req_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic dmem(input int n);
    wait_dreq();
    repeat (n) step();
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
  endtask

  initial begin : stimulus
    int base;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    // Reset state: everything low while rst is high.
    #2;
    check("reset_outputs", cur_snap(), 32'h0);
    check("reset_counters", {cycle_cnt[15:0], instret_cnt[15:0]}, 32'h0);
    do_reset();

    // ADD, zero-wait fetch: F1 D2 E3 W4.
    push_ir(1);
    push_done(1'b1, 4);
    fetch(0, C_ADD, 1'b0);

    // LW, dmem ack 3 cycles after MEM entry: M4..7, W8.
    push_ir(1);
    push_mem(1'b0, 4'b1111, 1'b1, 7);
    push_done(1'b1, 8);
    base = dreq_cyc;
    fetch(0, C_LW, 1'b0);
    dmem(3);
    step();
    check("lw_dmem_req_cycles", dreq_cyc - base, 32'd4);

    // SH with imem ack in the last allowed wait cycle (ack beats timeout).
    push_ir(8);
    push_mem(1'b1, 4'b0011, 1'b0, 11);
    push_done(1'b0, 12);
    fetch(7, C_SH, 1'b0);
    dmem(0);
    repeat (2) step();
    check("queue_drained_t1_3", exp_q.size(), 32'd0);

    // IMEM timeout: 8 FETCH cycles then TRAP; sticky against acks and halt.
    do_reset();
    push_trap(2'd2, 9);
    repeat (12) step();
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    halt = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (3) step();
    check("imem_to_sticky_trap", {30'd0, trap, bus.imem_req}, 32'd2);
    check("imem_to_sticky_cause", trap_cause, 32'd2);
    check("queue_drained_t4", exp_q.size(), 32'd0);

    // DMEM timeout: LW never acked, MEM occupies fcyc 4..11.
    do_reset();
    push_ir(1);
    push_trap(2'd3, 12);
    fetch(0, C_LW, 1'b0);
    repeat (14) step();
    check("dmem_to_cause", trap_cause, 32'd3);
    check("queue_drained_dmem_to", exp_q.size(), 32'd0);

    // Illegal in DECODE: trap without any write or data strobe.
    do_reset();
    push_ir(1);
    push_trap(2'd1, 3);
    base = strobe_cyc;
    fetch(0, C_SH, 1'b1);
    repeat (5) step();
    illegal = 1'b0;
    check("illegal_no_strobes", strobe_cyc - base, 32'd0);
    check("illegal_cause", trap_cause, 32'd1);
    check("queue_drained_t5", exp_q.size(), 32'd0);

    // Three ADDs then halt, counters, then reset in the middle of MEM.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_ir(1);
      push_done(1'b1, 4);
      fetch(0, C_ADD, 1'b0);
      if (i == 2) halt = 1'b1;
    end
    repeat (4) step();
    check("halted_in_idle", {30'd0, bus.imem_req, trap}, 32'd0);
`ifdef CPU_MC_PERF_EN
    check("cycle_cnt_3add", cycle_cnt, 32'd12);
    check("instret_cnt_3add", instret_cnt, 32'd3);
`else
    check("cycle_cnt_tied", cycle_cnt, 32'd0);
    check("instret_cnt_tied", instret_cnt, 32'd0);
`endif
    push_ir(1);
    halt = 1'b0;
    fetch(0, C_LW, 1'b0);
    wait_dreq();
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_mem_outputs", cur_snap(), 32'h0);
    check("rst_mid_mem_counters", cycle_cnt | instret_cnt, 32'h0);
    step();
    rst = 1'b0;
    check("after_rst_idle", bus.imem_req, 32'd0);
    step();
    check("after_rst_fetch", bus.imem_req, 32'd1);
    check("queue_drained_end", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
